// File: rtl/aes_pkg.sv
// Shared AES constants and helpers. Used by the key schedule and the cipher cores.
package aes_pkg;

    // AES-128 only: 10 rounds, 128-bit keys and blocks, 4 words per key.
    localparam int AES_NR       = 10;
    localparam int AES_KW       = 128;
    localparam int AES_BLOCK_W  = 128;
    localparam int AES_NK_WORDS = 4;

    // Key-schedule controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    // Round constant for rounds 1..10. Any other index is never used and yields 0.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[a];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file with a combinational read port; each key is also streamed out.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          rk_valid,
    output logic [3:0]    rk_index,
    output logic [KW-1:0] rk_data,
    input  logic [3:0]    rd_round,
    output logic [KW-1:0] rd_key
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ks_state_e     state_reg, state_next;
    logic [3:0]    counter_reg, counter_next;
    logic [KW-1:0] w_reg, w_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          rk_valid_reg, rk_valid_next;
    logic [3:0]    rk_index_reg, rk_index_next;
    logic [KW-1:0] rk_data_reg, rk_data_next;

    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [KW-1:0] wr_data;

    logic [KW-1:0] rk_mem [0:NR];

    // Round-function datapath on the current working words w0..w3.
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   rot, sub, temp;
    logic [31:0]   nw0, nw1, nw2, nw3;
    logic [KW-1:0] round_key;

    assign w0  = w_reg[127:96];
    assign w1  = w_reg[95:64];
    assign w2  = w_reg[63:32];
    assign w3  = w_reg[31:0];
    assign rot = rot_word(w3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot[8*gi +: 8]),
                .s (sub[8*gi +: 8])
            );
        end
    endgenerate

    assign temp      = sub ^ {rcon(counter_reg), 24'h0};
    assign nw0       = w0 ^ temp;
    assign nw1       = w1 ^ nw0;
    assign nw2       = w2 ^ nw1;
    assign nw3       = w3 ^ nw2;
    assign round_key = {nw0, nw1, nw2, nw3};

    // Next-state, register-file write and stream outputs.
    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        w_next        = w_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        rk_valid_next = 1'b0;
        rk_index_next = rk_index_reg;
        rk_data_next  = rk_data_reg;
        wr_en         = 1'b0;
        wr_idx        = 4'd0;
        wr_data       = '0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    // Round key 0 is the cipher key itself.
                    w_next        = key_in;
                    counter_next  = 4'd1;
                    rk_valid_next = 1'b1;
                    rk_index_next = 4'd0;
                    rk_data_next  = key_in;
                    busy_next     = 1'b1;
                    done_next     = 1'b0;
                    wr_en         = 1'b1;
                    wr_idx        = 4'd0;
                    wr_data       = key_in;
                    state_next    = EXPAND;
                end
            end
            EXPAND: begin
                // start is deliberately ignored here: no queueing.
                w_next        = round_key;
                counter_next  = counter_reg + 4'd1;
                rk_valid_next = 1'b1;
                rk_index_next = counter_reg;
                rk_data_next  = round_key;
                wr_en         = 1'b1;
                wr_idx        = counter_reg;
                wr_data       = round_key;
                if (counter_reg == LAST_ROUND) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller and stream registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            counter_reg  <= 4'd0;
            w_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rk_valid_reg <= 1'b0;
            rk_index_reg <= 4'd0;
            rk_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            w_reg        <= w_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rk_valid_reg <= rk_valid_next;
            rk_index_reg <= rk_index_next;
            rk_data_reg  <= rk_data_next;
        end
    end

    // Round-key register file; every entry clears on reset so consumers never
    // see stale keys after an abort.
    generate
        for (genvar gi = 0; gi <= NR; gi++) begin : g_rk_mem
            // Entry gi captures the key written with index gi.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rk_mem[gi] <= '0;
                end else if (wr_en && (wr_idx == 4'(gi))) begin
                    rk_mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Random-access read; addresses beyond the last round return zero.
    always_comb begin
        rd_key = '0;
        if (rd_round <= LAST_ROUND) begin
            rd_key = rk_mem[rd_round];
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rk_valid = rk_valid_reg;
    assign rk_index = rk_index_reg;
    assign rk_data  = rk_data_reg;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed testbench for aes_key_schedule using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] rk_data;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    int checks_cnt;
    int errors_cnt;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z   = 128'h0;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK2   = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_ALT = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_schedule dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .rk_valid (rk_valid),
        .rk_index (rk_index),
        .rk_data  (rk_data),
        .rd_round (rd_round),
        .rd_key   (rd_key)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rd_round = idx;
        #1;
        check(tag, rd_key, exp);
    endtask

    // Pulse start with key, follow the expansion to done and check timing and strobes.
    // If repulse_at > 0, start is raised again with alt_key before that expansion edge.
    task automatic run_expansion(input logic [127:0] key, input int repulse_at,
                                 input logic [127:0] alt_key);
        int         strobes;
        int         busy_cycles;
        int         done_at;
        logic [3:0] exp_idx;
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("t0_valid", rk_valid, 1);
        check("t0_index", rk_index, 0);
        check("t0_data",  rk_data,  key);
        check("t0_busy",  busy,     1);
        check("t0_done",  done,     0);
        strobes     = rk_valid ? 1 : 0;
        busy_cycles = busy ? 1 : 0;
        exp_idx     = 4'd1;
        done_at     = 0;
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            if (n == repulse_at) begin
                key_in = alt_key;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            if (rk_valid) begin
                strobes++;
                check("strobe_index", rk_index, exp_idx);
                exp_idx = exp_idx + 4'd1;
            end
            if (busy) busy_cycles++;
            if (done) done_at = n;
        end
        check("done_latency", done_at, 10);
        check("busy_cycles",  busy_cycles, 10);
        check("last_index",   rk_index, 10);
        tick();
        check("valid_drops",  rk_valid, 0);
        check("index_holds",  rk_index, 10);
        check("strobe_count", strobes, 11);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset      = 1'b1;
        start      = 1'b0;
        key_in     = '0;
        rd_round   = 4'd0;
        #25;
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_valid",    rk_valid, 0);
        check("rst_index",    rk_index, 0);
        check("rst_data",     rk_data, 0);
        check_rd("rst_rk0", 4'd0, 0);
        #3;
        reset = 1'b0;
        tick();

        // FIPS-197 A.1 key.
        run_expansion(KEY_A, 0, KEY_ALT);
        check_rd("a_rk0",  4'd0,  KEY_A);
        check_rd("a_rk1",  4'd1,  A_RK1);
        check_rd("a_rk2",  4'd2,  A_RK2);
        check_rd("a_rk10", 4'd10, A_RK10);

        // Restart from DONE with the all-zero key.
        run_expansion(KEY_Z, 0, KEY_ALT);
        check_rd("z_rk0",  4'd0,  KEY_Z);
        check_rd("z_rk1",  4'd1,  Z_RK1);
        check_rd("z_rk2",  4'd2,  Z_RK2);
        check_rd("z_rk10", 4'd10, Z_RK10);
        check_rd("rd_oob15", 4'd15, 0);
        check_rd("rd_oob11", 4'd11, 0);

        // start re-pulsed mid-expansion must be ignored.
        run_expansion(KEY_A, 4, KEY_ALT);
        check_rd("ign_rk1",  4'd1,  A_RK1);
        check_rd("ign_rk10", 4'd10, A_RK10);

        // Asynchronous reset during expansion.
        key_in = KEY_Z;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        check("pre_rst_busy", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy",  busy, 0);
        check("arst_done",  done, 0);
        check("arst_valid", rk_valid, 0);
        check("arst_data",  rk_data, 0);
        for (int i = 0; i <= 10; i++) begin
            check_rd("arst_rk", 4'(i), 0);
        end
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        run_expansion(KEY_A, 0, KEY_ALT);
        check_rd("post_rk1",  4'd1,  A_RK1);
        check_rd("post_rk10", 4'd10, A_RK10);

        // start held high from IDLE: accepted, ignored, re-accepted after done.
        #3;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        begin
            int done_at;
            key_in  = KEY_Z;
            start   = 1'b1;
            tick();
            check("held_t0_index", rk_index, 0);
            check("held_t0_valid", rk_valid, 1);
            done_at = 0;
            for (int n = 1; n <= 20 && done_at == 0; n++) begin
                tick();
                if (done) done_at = n;
            end
            check("held_done_latency", done_at, 10);
            tick();
            check("held_restart_valid", rk_valid, 1);
            check("held_restart_index", rk_index, 0);
            check("held_restart_done",  done, 0);
            check("held_restart_busy",  busy, 1);
            start   = 1'b0;
            done_at = 0;
            for (int n = 1; n <= 20 && done_at == 0; n++) begin
                tick();
                if (done) done_at = n;
            end
            check("held2_done_latency", done_at, 10);
            check_rd("held_rk10", 4'd10, Z_RK10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
